// File: rtl/ram_master_pkg.sv
// ram_master_pkg: shared FSM state encoding and width constants for ram_master.
package ram_master_pkg;
    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_WAIT, RD_DATA} state_e;
    localparam int WSW = 3;
    localparam int LW_DEFAULT = 4;
endpackage

// File: rtl/ram_master.sv
// ram_master: host valid/ready requests to synchronous RAM strobe cycles with WS read wait states.
// Define RAM_MASTER_BURST_EN to add REQ_LEN and multi-word read bursts.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int WS = 0
`ifdef RAM_MASTER_BURST_EN
    , parameter int LW = LW_DEFAULT
`endif
) (
    input  logic            CLK,
    input  logic            nRES,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic            REQ_WE,
    input  logic [DW/8-1:0] REQ_BE,
    input  logic [AW-1:0]   REQ_A,
    input  logic [DW-1:0]   REQ_D,
`ifdef RAM_MASTER_BURST_EN
    input  logic [LW-1:0]   REQ_LEN,
`endif
    output logic            RSP_VALID,
    output logic [DW-1:0]   RSP_D,
    output logic            BUSY,
    output logic            RAM_nCE,
    output logic            RAM_nWE,
    output logic            RAM_nOE,
    output logic [DW/8-1:0] RAM_nBE,
    output logic [AW-1:0]   RAM_A,
    output logic [DW-1:0]   RAM_DO,
    input  logic [DW-1:0]   RAM_DI
);
`ifndef RAM_MASTER_BURST_EN
    localparam int LW = LW_DEFAULT;
`endif
    state_e          state_q;
    logic            nce_q, nwe_q, noe_q, rsp_v_q;
    logic [DW/8-1:0] nbe_q;
    logic [AW-1:0]   a_q;
    logic [DW-1:0]   do_q, rsp_d_q;
    logic [WSW-1:0]  cnt_q;
    logic [LW-1:0]   len_q, req_len;

`ifdef RAM_MASTER_BURST_EN
    assign req_len = REQ_LEN;
`else
    assign req_len = '0;
`endif

    assign REQ_READY = state_q == IDLE;
    assign BUSY      = state_q != IDLE;
    assign RSP_VALID = rsp_v_q;
    assign RSP_D     = rsp_d_q;
    assign RAM_nCE   = nce_q;
    assign RAM_nWE   = nwe_q;
    assign RAM_nOE   = noe_q;
    assign RAM_nBE   = nbe_q;
    assign RAM_A     = a_q;
    assign RAM_DO    = do_q;

    // RAM read data lags its address by one edge, so the next burst address
    // is issued on the edge entering RD_DATA while the current word is captured.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q <= IDLE;
            nce_q   <= 1'b1;
            nwe_q   <= 1'b1;
            noe_q   <= 1'b1;
            nbe_q   <= '1;
            a_q     <= '0;
            do_q    <= '0;
            rsp_v_q <= 1'b0;
            rsp_d_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            rsp_v_q <= 1'b0;
            case (state_q)
                IDLE: if (REQ_VALID) begin
                    a_q   <= REQ_A;
                    nce_q <= 1'b0;
                    if (REQ_WE) begin
                        state_q <= WR;
                        nwe_q   <= 1'b0;
                        nbe_q   <= ~REQ_BE;
                        do_q    <= REQ_D;
                    end else begin
                        state_q <= RD_ADDR;
                        noe_q   <= 1'b0;
                        len_q   <= req_len;
                    end
                end
                WR: begin
                    state_q <= IDLE;
                    nce_q   <= 1'b1;
                    nwe_q   <= 1'b1;
                    nbe_q   <= '1;
                end
                RD_ADDR: begin
                    state_q <= (WS > 0) ? RD_WAIT : RD_DATA;
                    cnt_q   <= WSW'(WS - 1);
                    if (WS == 0 && len_q != '0) a_q <= a_q + AW'(1);
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RD_DATA;
                        if (len_q != '0) a_q <= a_q + AW'(1);
                    end else begin
                        cnt_q <= cnt_q - WSW'(1);
                    end
                end
                RD_DATA: begin
                    rsp_v_q <= 1'b1;
                    rsp_d_q <= RAM_DI;
                    if (len_q == '0) begin
                        state_q <= IDLE;
                        nce_q   <= 1'b1;
                        noe_q   <= 1'b1;
                    end else begin
                        len_q   <= len_q - LW'(1);
                        state_q <= (WS > 0) ? RD_WAIT : RD_DATA;
                        cnt_q   <= WSW'(WS - 1);
                        if (WS == 0 && len_q > LW'(1)) a_q <= a_q + AW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed scoreboard bench for ram_master with WS=0 and WS=3 instances on RAM models.
module tb_ram_master;
    typedef struct packed {logic [31:0] d; int t;} exp_t;

    logic CLK = 1'b0, nRES = 1'b0;
    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    int vec = 0, mis = 0;
    exp_t q0[$], q3[$];
    logic [31:0] model [logic [15:0]];

    logic rv0 = 0, we0 = 0, rdy0, rspv0, busy0, nce0, nwe0, noe0;
    logic [3:0] be0 = 0, len0 = 0, nbe0;
    logic [15:0] a0 = 0, ra0;
    logic [31:0] d0 = 0, rspd0, rdo0, dout0;
    logic [31:0] mem0 [0:65535];
    wire  [31:0] di0;
    logic rv3 = 0, we3 = 0, rdy3, rspv3, busy3, nce3, nwe3, noe3;
    logic [3:0] be3 = 0, len3 = 0, nbe3;
    logic [15:0] a3 = 0, ra3;
    logic [31:0] d3 = 0, rspd3, rdo3, dout3;
    logic [31:0] mem3 [0:65535];
    wire  [31:0] di3;

    ram_master #(.WS(0)) u0 (.CLK(CLK), .nRES(nRES), .REQ_VALID(rv0), .REQ_READY(rdy0), .REQ_WE(we0),
        .REQ_BE(be0), .REQ_A(a0), .REQ_D(d0),
`ifdef RAM_MASTER_BURST_EN
        .REQ_LEN(len0),
`endif
        .RSP_VALID(rspv0), .RSP_D(rspd0), .BUSY(busy0), .RAM_nCE(nce0), .RAM_nWE(nwe0),
        .RAM_nOE(noe0), .RAM_nBE(nbe0), .RAM_A(ra0), .RAM_DO(rdo0), .RAM_DI(di0));

    ram_master #(.WS(3)) u3 (.CLK(CLK), .nRES(nRES), .REQ_VALID(rv3), .REQ_READY(rdy3), .REQ_WE(we3),
        .REQ_BE(be3), .REQ_A(a3), .REQ_D(d3),
`ifdef RAM_MASTER_BURST_EN
        .REQ_LEN(len3),
`endif
        .RSP_VALID(rspv3), .RSP_D(rspd3), .BUSY(busy3), .RAM_nCE(nce3), .RAM_nWE(nwe3),
        .RAM_nOE(noe3), .RAM_nBE(nbe3), .RAM_A(ra3), .RAM_DO(rdo3), .RAM_DI(di3));

    always @(posedge CLK) begin
        if (!nce0 && !nwe0) for (int b = 0; b < 4; b++) if (!nbe0[b]) mem0[ra0][b*8+:8] <= rdo0[b*8+:8];
        if (!nce0 && !noe0) dout0 <= mem0[ra0];
        if (!nce3 && !nwe3) for (int b = 0; b < 4; b++) if (!nbe3[b]) mem3[ra3][b*8+:8] <= rdo3[b*8+:8];
        if (!nce3 && !noe3) dout3 <= mem3[ra3];
    end
    assign di0 = (!nce0 && !noe0) ? dout0 : 'z;
    assign di3 = (!nce3 && !noe3) ? dout3 : 'z;

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    function automatic logic [31:0] mrd(input logic [15:0] a);
        return model.exists(a) ? model[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            mis++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) if (nRES && rspv0) begin
        exp_t e;
        chk("rsp0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("rsp0_data", rspd0, e.d);
            chk("rsp0_cycle", cyc, e.t);
        end
    end

    always @(negedge CLK) if (nRES && rspv3) begin
        exp_t e;
        chk("rsp3_expected", 32'(q3.size() != 0), 32'd1);
        if (q3.size() != 0) begin
            e = q3.pop_front();
            chk("rsp3_data", rspd3, e.d);
            chk("rsp3_cycle", cyc, e.t);
        end
    end

    always @(negedge CLK) if (nRES && (!nwe0 || !nwe3)) begin
        chk("we_oe_overlap0", {nwe0, noe0} == 2'b00, 1'b0);
        chk("we_oe_overlap3", {nwe3, noe3} == 2'b00, 1'b0);
    end

    task automatic req0(input logic we, input logic [3:0] be, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] len, output int t);
        int n = 0;
        logic [31:0] old;
        rv0 = 1; we0 = we; be0 = be; a0 = a; d0 = d; len0 = len;
        @(negedge CLK);
        while (!rdy0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("accept_ready", rdy0, 1'b1);
        @(posedge CLK);
        #1 t = cyc;
        if (we) begin
            old = mrd(a);
            for (int b = 0; b < 4; b++) if (be[b]) old[b*8+:8] = d[b*8+:8];
            model[a] = old;
        end else begin
`ifdef RAM_MASTER_BURST_EN
            for (int k = 0; k <= int'(len); k++) q0.push_back('{mrd(a + 16'(k)), t + 2 + k});
`else
            q0.push_back('{mrd(a), t + 2});
`endif
        end
    endtask

    initial begin
        int t, t1, t2, t3, t4, nc, no, nr;
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = init_val(16'(i));
            mem3[i] = init_val(16'(i));
        end
        repeat (3) @(negedge CLK);
        chk("rst_nce", nce0, 1'b1);
        chk("rst_nwe", nwe0, 1'b1);
        chk("rst_noe", noe0, 1'b1);
        chk("rst_nbe", nbe0, 4'hF);
        chk("rst_a", ra0, 16'h0);
        chk("rst_do", rdo0, 32'h0);
        chk("rst_rspv", rspv0, 1'b0);
        chk("rst_rspd", rspd0, 32'h0);
        chk("rst_busy", busy0, 1'b0);
        nRES = 1;
        @(negedge CLK);
        chk("rst_ready0", rdy0, 1'b1);
        chk("rst_ready3", rdy3, 1'b1);

        req0(1, 4'hF, 16'h0010, 32'hDEADBEEF, 0, t);
        rv0 = 0;
        @(negedge CLK);
        chk("wr_nce", nce0, 1'b0);
        chk("wr_nwe", nwe0, 1'b0);
        chk("wr_noe", noe0, 1'b1);
        chk("wr_nbe", nbe0, 4'h0);
        chk("wr_a", ra0, 16'h0010);
        chk("wr_do", rdo0, 32'hDEADBEEF);
        chk("wr_busy", busy0, 1'b1);
        chk("wr_ready", rdy0, 1'b0);
        req0(0, 4'h0, 16'h0010, 0, 0, t);
        rv0 = 0;
        @(negedge CLK);
        chk("rd_nce", nce0, 1'b0);
        chk("rd_noe", noe0, 1'b0);
        chk("rd_nwe", nwe0, 1'b1);
        chk("rd_nbe", nbe0, 4'hF);
        repeat (3) @(negedge CLK);

        req0(1, 4'b0010, 16'h0010, 32'h0000AA00, 0, t);
        req0(0, 4'h0, 16'h0010, 0, 0, t);
        req0(1, 4'b0000, 16'h0010, 32'hFFFFFFFF, 0, t);
        req0(0, 4'hF, 16'h0010, 0, 0, t);
        rv0 = 0;
        repeat (6) @(negedge CLK);
        chk("rspd_hold", rspd0, mrd(16'h0010));

        rv3 = 1; we3 = 0; be3 = 4'hF; a3 = 16'h0020;
        @(posedge CLK);
        #1 t = cyc;
        rv3 = 0;
        q3.push_back('{init_val(16'h0020), t + 5});
        nc = 0; no = 0; nr = 0;
        repeat (8) begin
            @(negedge CLK);
            nc += int'(!nce3);
            no += int'(!noe3);
            nr += int'(!rdy3);
        end
        chk("ws3_nce_cycles", nc, 5);
        chk("ws3_noe_cycles", no, 5);
        chk("ws3_notready_cycles", nr, 5);

        req0(1, 4'hF, 16'h1234, 32'h11112222, 0, t1);
        req0(0, 4'hF, 16'h1234, 0, 0, t2);
        req0(1, 4'hF, 16'h5678, 32'h33334444, 0, t3);
        req0(0, 4'hF, 16'h5678, 0, 0, t4);
        rv0 = 0;
        chk("alt_wr_gap", t2 - t1, 2);
        chk("alt_rd_gap", t3 - t2, 3);
        chk("alt_wr_gap2", t4 - t3, 2);
        repeat (5) @(negedge CLK);

        rv3 = 1; we3 = 0; a3 = 16'h0030;
        @(posedge CLK);
        #1 rv3 = 0;
        repeat (2) @(negedge CLK);
        chk("pre_rst_busy3", busy3, 1'b1);
        #2 nRES = 0;
        #1;
        chk("mid_rst_nce", nce3, 1'b1);
        chk("mid_rst_noe", noe3, 1'b1);
        chk("mid_rst_busy", busy3, 1'b0);
        q3.delete();
        @(negedge CLK);
        nRES = 1;
        repeat (8) @(negedge CLK);
        chk("post_rst_ready", rdy3, 1'b1);

`ifdef RAM_MASTER_BURST_EN
        req0(0, 4'hF, 16'hFFFE, 0, 4'd3, t);
        rv0 = 0;
        repeat (3) @(negedge CLK);
        chk("burst_busy", busy0, 1'b1);
        repeat (6) @(negedge CLK);
`endif
        chk("q0_drained", q0.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
